// File: rtl/nco_quad_sync.sv
// Phase-accumulator NCO with I/Q square outputs and wrap tick; outputs are registered one cycle after acc.
// The tuning word is taken on tw_valid & tw_ready; with SYNC_UPDATE it is held pending (tw_ready=0) until commit.
module nco_quad_sync #(
    parameter int ACC_W       = 32,
    parameter int PHASE_W     = 12,
    parameter int SYNC_UPDATE = 1
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [ACC_W-1:0]   tw_in,
    input  logic               tw_valid,
    output logic               tw_ready,
    input  logic [ACC_W-1:0]   phase_off,
    input  logic               sync_clr,
    output logic               dco_out,
    output logic               dco_q,
    output logic [PHASE_W-1:0] phase_out,
    output logic               wrap_tick,
    output logic [ACC_W-1:0]   tw_active
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   tw_active_q, tw_active_d;
    logic [ACC_W-1:0]   pend_tw_q, pend_tw_d;
    logic               dco_out_q, dco_out_d;
    logic               dco_q_q, dco_q_d;
    logic [PHASE_W-1:0] phase_out_q, phase_out_d;
    logic               wrap_tick_q, wrap_tick_d;

    logic [ACC_W:0]     sum_full;
    logic [ACC_W-1:0]   phase;
    logic               phase_unused;
    logic               carry;
    logic               transfer;
    logic               pend_release;
    logic               commit;

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: only the synchronous-update variant ever leaves IDLE
    always_comb begin
        state_d = state_q;
        if (SYNC_UPDATE != 0) begin
            case (state_q)
                ST_IDLE: if (transfer)     state_d = ST_PEND;
                ST_PEND: if (pend_release) state_d = ST_IDLE;
                default:                   state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        tw_ready = (state_q == ST_IDLE);
        commit   = (state_q == ST_PEND) && pend_release;
    end

    assign transfer = tw_valid & tw_ready;

    always_comb begin
        sum_full = {1'b0, acc_q} + {1'b0, tw_active_q};
        carry    = en & ~sync_clr & sum_full[ACC_W];
        // A zero word never wraps, so it must not gate the commit
        pend_release = carry | sync_clr | (tw_active_q == '0);

        acc_d = acc_q;
        if (sync_clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum_full[ACC_W-1:0];
        end

        tw_active_d = tw_active_q;
        pend_tw_d   = pend_tw_q;
        if (SYNC_UPDATE == 0) begin
            if (transfer) tw_active_d = tw_in;
        end else begin
            if (transfer) pend_tw_d   = tw_in;
            if (commit)   tw_active_d = pend_tw_q;
        end

        phase        = acc_q + phase_off;
        phase_unused = ^phase;
        dco_out_d    = phase[ACC_W-1];
        // Adding a quarter turn flips the MSB exactly when bit ACC_W-2 is set
        dco_q_d      = phase[ACC_W-1] ^ phase[ACC_W-2];
        phase_out_d  = phase[ACC_W-1 -: PHASE_W];
        wrap_tick_d  = carry;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            tw_active_q <= '0;
            pend_tw_q   <= '0;
            dco_out_q   <= 1'b0;
            dco_q_q     <= 1'b0;
            phase_out_q <= '0;
            wrap_tick_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            tw_active_q <= tw_active_d;
            pend_tw_q   <= pend_tw_d;
            dco_out_q   <= dco_out_d;
            dco_q_q     <= dco_q_d;
            phase_out_q <= phase_out_d;
            wrap_tick_q <= wrap_tick_d;
        end
    end

    assign dco_out   = dco_out_q;
    assign dco_q     = dco_q_q;
    assign phase_out = phase_out_q;
    assign wrap_tick = wrap_tick_q;
    assign tw_active = tw_active_q;

endmodule

// File: tb/tb_nco_quad_sync.sv
// Bench for nco_quad_sync: an immediate-update and a wrap-synchronised instance share one stimulus stream.
module tb_nco_quad_sync;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0, en = 1'b0, tw_valid = 1'b0, sync_clr = 1'b0;
    logic [31:0] tw_in = '0, phase_off = '0;

    logic        rdy0, rdy1, dco0, dco1, q0, q1, wt0, wt1;
    logic [11:0] ph0, ph1;
    logic [31:0] twa0, twa1;

    always #5 sys_clk = ~sys_clk;

    nco_quad_sync #(.ACC_W(32), .PHASE_W(12), .SYNC_UPDATE(0)) u_s0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .tw_in(tw_in), .tw_valid(tw_valid),
        .tw_ready(rdy0), .phase_off(phase_off), .sync_clr(sync_clr), .dco_out(dco0),
        .dco_q(q0), .phase_out(ph0), .wrap_tick(wt0), .tw_active(twa0));

    nco_quad_sync #(.ACC_W(32), .PHASE_W(12), .SYNC_UPDATE(1)) u_s1 (
        .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .tw_in(tw_in), .tw_valid(tw_valid),
        .tw_ready(rdy1), .phase_off(phase_off), .sync_clr(sync_clr), .dco_out(dco1),
        .dco_q(q1), .phase_out(ph1), .wrap_tick(wt1), .tw_active(twa1));

    typedef struct packed {
        logic        dco;
        logic        dq;
        logic [11:0] ph;
        logic        wt;
        logic [31:0] twa;
        logic        rdy;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_acc[2], m_tw[2], m_pend[2];
    bit          m_pf[2];
    int          checks = 0, errors = 0;
    int          ticks0 = 0, ticks1 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, push model expectations, compare after posedge
    task automatic step(input logic r, input logic e, input logic c, input logic v,
                        input logic [31:0] tw, input logic [31:0] off);
        exp_t        x, o;
        logic [32:0] s;
        logic [31:0] p, pq;
        logic        cy;
        @(negedge sys_clk);
        rst_n = r; en = e; sync_clr = c; tw_valid = v; tw_in = tw; phase_off = off;
        for (int k = 0; k < 2; k++) begin
            x = '0;
            if (!r) begin
                m_acc[k] = '0; m_tw[k] = '0; m_pend[k] = '0; m_pf[k] = 1'b0;
            end else begin
                s  = {1'b0, m_acc[k]} + {1'b0, m_tw[k]};
                cy = e && !c && (s >= 33'h1_0000_0000);
                p  = m_acc[k] + off;
                pq = p + 32'h4000_0000;
                x.dco = p[31];
                x.dq  = pq[31];
                x.ph  = p[31:20];
                x.wt  = cy;
                if (k == 0) begin
                    if (v) m_tw[k] = tw;
                end else if (m_pf[k]) begin
                    if (cy || c || m_tw[k] == 0) begin
                        m_tw[k] = m_pend[k];
                        m_pf[k] = 1'b0;
                    end
                end else if (v) begin
                    m_pend[k] = tw;
                    m_pf[k]   = 1'b1;
                end
                m_acc[k] = c ? 32'h0 : (e ? s[31:0] : m_acc[k]);
            end
            x.twa = m_tw[k];
            x.rdy = (k == 0) ? 1'b1 : !m_pf[k];
            exp_q.push_back(x);
        end
        @(posedge sys_clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            x = exp_q.pop_front();
            if (k == 0) o = '{dco: dco0, dq: q0, ph: ph0, wt: wt0, twa: twa0, rdy: rdy0};
            else        o = '{dco: dco1, dq: q1, ph: ph1, wt: wt1, twa: twa1, rdy: rdy1};
            chk($sformatf("s%0d.dco_out", k),   32'(o.dco), 32'(x.dco));
            chk($sformatf("s%0d.dco_q", k),     32'(o.dq),  32'(x.dq));
            chk($sformatf("s%0d.phase_out", k), 32'(o.ph),  32'(x.ph));
            chk($sformatf("s%0d.wrap_tick", k), 32'(o.wt),  32'(x.wt));
            chk($sformatf("s%0d.tw_active", k), o.twa,      x.twa);
            chk($sformatf("s%0d.tw_ready", k),  32'(o.rdy), 32'(x.rdy));
        end
        if (wt0 === 1'b1) ticks0++;
        if (wt1 === 1'b1) ticks1++;
    endtask

    task automatic run(input int n, input logic [31:0] off);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, off);
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0);
        chk("reset.tw_ready1", 32'(rdy1), 32'h1);
        chk("reset.tw_active1", twa1, 32'h0);

        // Quarter-turn word from reset; sync instance commits via the zero-word rule
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h4000_0000, 32'h0);
        chk("zero_rule.tw_ready_drop", 32'(rdy1), 32'h0);
        ticks0 = 0; ticks1 = 0;
        run(16, 32'h0);
        chk("quarter.ticks_s0", 32'(ticks0), 32'd4);
        chk("quarter.ticks_s1", 32'(ticks1), 32'd3);
        chk("quarter.tw_active_s0", twa0, 32'h4000_0000);

        // Eighth-turn word, then a mid-period switch to a quarter turn
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h2000_0000, 32'h0);
        run(11, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h4000_0000, 32'h0);
        chk("sync_switch.tw_ready", 32'(rdy1), 32'h0);
        run(12, 32'h0);
        chk("sync_switch.tw_active", twa1, 32'h4000_0000);

        // Half-turn offset inverts the in-phase output
        run(12, 32'h8000_0000);

        // Hold with a pending word, held valid with other data, then clear commits it
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0000, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0BAD_0000, 32'h0);
        chk("hold.still_pending", 32'(rdy1), 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("clr.commit", twa1, 32'h1000_0000);
        run(3, 32'h0);

        // Reset in the middle of PEND discards the word
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h2000_0000, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst_pend.tw_active", twa1, 32'h0);
        chk("rst_pend.tw_ready", 32'(rdy1), 32'h1);

        // All-ones word counts down; Nyquist word toggles every cycle
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
        run(10, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h0);
        run(8, 32'h0);

        // Mixed random traffic
        for (int i = 0; i < 120; i++) begin
            logic [31:0] w;
            case ($urandom_range(0, 4))
                0:       w = 32'h0;
                1:       w = 32'h8000_0000;
                2:       w = 32'hFFFF_FFFF;
                default: w = $urandom;
            endcase
            step(($urandom_range(0, 40) != 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 12) == 0), ($urandom_range(0, 3) == 0),
                 w, ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
